// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request/response handshake plus the preload write port.
interface imem_responder_if #(
  parameter int xlen = 32
);
  logic [xlen-1:0] target_address;
  logic            req_valid;
  logic            hold;
  logic            flush;
  logic [xlen-1:0] resp;
  logic            resp_valid;
  logic [xlen-1:0] resp_addr;
  logic            fault;
  logic            load_en;
  logic [xlen-1:0] load_addr;
  logic [xlen-1:0] load_data;

  modport master (
    output target_address, req_valid, hold, flush, load_en, load_addr, load_data,
    input  resp, resp_valid, resp_addr, fault
  );

  modport slave (
    input  target_address, req_valid, hold, flush, load_en, load_addr, load_data,
    output resp, resp_valid, resp_addr, fault
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array with a side preload port and a LATENCY-deep response pipeline
// supporting hold (freeze) and flush (kill in-flight requests).
module imem_responder #(
  parameter int              xlen    = 32,
  parameter int              DEPTH   = 1024,
  parameter logic [xlen-1:0] BASE    = '0,
  parameter int              LATENCY = 1,
  parameter logic [xlen-1:0] NOP     = 'h13
) (
  input logic            clk,
  input logic            rst_n,
  imem_responder_if.slave bus
);
  localparam int          IDX_W   = $clog2(DEPTH);
  localparam int          LAST    = LATENCY - 1;
  localparam logic [xlen:0] DEPTH_X = (xlen + 1)'(DEPTH);

  logic [xlen-1:0] mem [DEPTH];

  logic            vld_p  [LATENCY];
  logic            flt_p  [LATENCY];
  logic [xlen-1:0] addr_p [LATENCY];
  logic [xlen-1:0] data_p [LATENCY];

  logic req_fault;

  // A borrow from the extended subtract lands in the upper bits, so below-BASE addresses fail the depth compare too.
  function automatic logic in_range(input logic [xlen-1:0] a);
    return ((({1'b0, a} - {1'b0, BASE}) >> 2) < DEPTH_X);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [xlen-1:0] a);
    return IDX_W'((a - BASE) >> 2);
  endfunction

  assign req_fault = (bus.target_address[1:0] != 2'b00) || !in_range(bus.target_address);

  always_ff @(posedge clk) begin
    if (bus.load_en && in_range(bus.load_addr)) begin
      mem[word_index(bus.load_addr)] <= bus.load_data;
    end
  end

  // Stage 0 captures the request; later stages shift. addr/fault only follow valid entries so the
  // last stage keeps the address of the most recent response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        flt_p[i]  <= 1'b0;
        addr_p[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else if (!bus.hold) begin
      vld_p[0] <= bus.req_valid;
      if (bus.req_valid) begin
        flt_p[0]  <= req_fault;
        addr_p[0] <= bus.target_address;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) begin
          flt_p[i]  <= flt_p[i-1];
          addr_p[i] <= addr_p[i-1];
        end
      end
    end
  end

  // Synchronous array read in stage 0; read-before-write against the preload port falls out of the NBA ordering.
  always_ff @(posedge clk) begin
    if (!bus.hold) begin
      if (bus.req_valid && !req_fault) begin
        data_p[0] <= mem[word_index(bus.target_address)];
      end
      for (int i = 1; i < LATENCY; i++) begin
        data_p[i] <= data_p[i-1];
      end
    end
  end

  // Output stage
  assign bus.resp_valid = vld_p[LAST];
  assign bus.fault      = vld_p[LAST] && flt_p[LAST];
  assign bus.resp       = (vld_p[LAST] && !flt_p[LAST]) ? data_p[LAST] : NOP;
  assign bus.resp_addr  = addr_p[LAST];
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: queue-based response model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_imem_responder;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 3;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] NOP   = 32'h13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  imem_responder_if #(.xlen(XLEN)) bus ();

  imem_responder #(
    .xlen(XLEN), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT), .NOP(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        flt;
    int          age;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        flt;
  } rsp_t;

  ent_t        pend [$];
  rsp_t        got  [$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] base_m    = BASE;
  logic        exp_valid = 1'b0;
  logic        exp_fault = 1'b0;
  logic [31:0] exp_resp  = NOP;
  logic [31:0] exp_addr  = 32'h0;
  logic        adv_edge  = 1'b0;
  bit          chk_en    = 1'b0;

  function automatic bit word_ok(input logic [31:0] a);
    if (a < base_m) return 1'b0;
    return ((a - base_m) / 4) < 32'(DEPTH);
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || !word_ok(a);
  endfunction

  // Each accepted request ages by one per advancing edge and is visible while its age equals LAT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_resp  = NOP;
      exp_addr  = 32'h0;
      adv_edge  = 1'b0;
    end else begin
      ent_t e;
      adv_edge = !bus.hold || bus.flush;
      if (bus.flush) begin
        pend.delete();
      end else if (!bus.hold) begin
        foreach (pend[i]) pend[i].age++;
        while (pend.size() > 0 && pend[0].age > LAT) void'(pend.pop_front());
        if (bus.req_valid) begin
          e.addr = bus.target_address;
          e.flt  = addr_bad(e.addr);
          if (e.flt) e.data = NOP;
          else       e.data = mem_m[int'((e.addr - base_m) / 4)];
          e.age  = 1;
          pend.push_back(e);
        end
      end
      if (bus.load_en && word_ok(bus.load_addr))
        mem_m[int'((bus.load_addr - base_m) / 4)] = bus.load_data;
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_resp  = NOP;
      foreach (pend[i]) begin
        if (pend[i].age == LAT) begin
          exp_valid = 1'b1;
          exp_fault = pend[i].flt;
          exp_resp  = pend[i].data;
          exp_addr  = pend[i].addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
      check("resp",       bus.resp,            exp_resp);
      check("fault",      32'(bus.fault),      32'(exp_fault));
      check("resp_addr",  bus.resp_addr,       exp_addr);
      if (bus.resp_valid === 1'b1 && adv_edge)
        got.push_back('{addr: bus.resp_addr, data: bus.resp, flt: bus.fault});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rv, input logic [31:0] a, input logic h, input logic f);
    bus.req_valid      = rv;
    bus.target_address = a;
    bus.hold           = h;
    bus.flush          = f;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    idle(1);
    bus.load_en   = 1'b0;
  endtask

  task automatic check_got(input string name, input int idx, input logic [31:0] a,
                           input logic [31:0] d, input logic flt);
    if (idx >= got.size()) begin
      check({name, "_present"}, 32'(got.size()), 32'(idx + 1));
    end else begin
      check({name, "_addr"},  got[idx].addr,      a);
      check({name, "_data"},  got[idx].data,      d);
      check({name, "_fault"}, 32'(got[idx].flt),  32'(flt));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] frozen;
    bus.req_valid = 1'b0; bus.target_address = 32'h0; bus.hold = 1'b0; bus.flush = 1'b0;
    bus.load_en = 1'b0;   bus.load_addr = 32'h0;      bus.load_data = 32'h0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) load(32'(4 * i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 8; i++) load(32'(32 + 4 * i), 32'hB000_0000 + 32'(i));

    // Reset with requests streaming: nothing comes back, then first response LAT cycles after a request.
    idle(3);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      check("t1_rst_valid", 32'(bus.resp_valid), 32'h0);
      check("t1_rst_resp",  bus.resp,            32'h13);
      check("t1_rst_fault", 32'(bus.fault),      32'h0);
      check("t1_rst_addr",  bus.resp_addr,       32'h0);
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b1; bus.target_address = 32'h8;
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("t1_latency",    32'(n),        32'd3);
    check("t1_first_resp", bus.resp,      32'hA000_0002);
    check("t1_first_addr", bus.resp_addr, 32'h8);
    idle(4);

    // Back-to-back stream of eight words
    got.delete();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
    idle(6);
    check("t2_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) check_got("t2", i, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);

    // Misaligned and out-of-range fetches
    got.delete();
    drive(1'b1, 32'h2,    1'b0, 1'b0);
    drive(1'b1, 32'h1000, 1'b0, 1'b0);
    idle(5);
    check("t3_count", 32'(got.size()), 32'd2);
    check_got("t3_misaligned", 0, 32'h2,    32'h13, 1'b1);
    check_got("t3_range",      1, 32'h1000, 32'h13, 1'b1);

    // Flush: 0x0 has already reached the output when the flush edge arrives; 0x4, 0x8, 0xC are killed.
    got.delete();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b1);
    check("t4_after_flush_valid", 32'(bus.resp_valid), 32'h0);
    check("t4_after_flush_resp",  bus.resp,            32'h13);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    idle(5);
    check("t4_count", 32'(got.size()), 32'd2);
    check_got("t4_pre",  0, 32'h0,  32'hA000_0000, 1'b0);
    check_got("t4_post", 1, 32'h10, 32'hA000_0004, 1'b0);

    // Hold for five cycles mid-stream; requests offered during hold are never answered.
    got.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
    frozen = bus.resp;
    check("t5_frozen_value", frozen, 32'hA000_0001);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h20, 1'b1, 1'b0);
      check("t5_hold_resp",  bus.resp,            frozen);
      check("t5_hold_valid", 32'(bus.resp_valid), 32'h1);
    end
    idle(5);
    check("t5_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_got("t5", i, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);

    // hold together with flush empties the pipeline
    got.delete();
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    drive(1'b1, 32'h18, 1'b1, 1'b1);
    check("t5_holdflush_valid", 32'(bus.resp_valid), 32'h0);
    idle(4);
    check("t5_holdflush_count", 32'(got.size()), 32'd0);

    // Load/read collision, out-of-range load, misaligned load
    got.delete();
    load(32'h14, 32'h1111);
    bus.load_en = 1'b1; bus.load_addr = 32'h14; bus.load_data = 32'h2222;
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    bus.load_en = 1'b0;
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    load(32'h1000, 32'hDEAD_BEEF);
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    load(32'h17, 32'h3333);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    idle(5);
    check("t6_count", 32'(got.size()), 32'd4);
    check_got("t6_old",     0, 32'h14, 32'h1111,      1'b0);
    check_got("t6_new",     1, 32'h14, 32'h2222,      1'b0);
    check_got("t6_nowrap",  2, 32'h0,  32'hA000_0000, 1'b0);
    check_got("t6_lowbits", 3, 32'h14, 32'h3333,      1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
